// File: rtl/sipo_word_deser_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
//
// Shared definitions for the sipo_word_deser deserialiser slice.
//
// Contents:
//   MSB_FIRST_ORDER / LSB_FIRST_ORDER : encodings for the MSB_FIRST parameter
//   clog2_cnt(width)                  : width of a counter able to hold
//                                       0..width, used to size bit_count
// ---------------------------------------------------------------------------
package sipo_pkg;

  // Bit-order encodings for the MSB_FIRST parameter.
  localparam int MSB_FIRST_ORDER = 1;
  localparam int LSB_FIRST_ORDER = 0;

  // Legal word-size range for the deserialiser.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Number of bits needed to represent the values 0..width, i.e.
  // $clog2(width+1). Written as a bounded loop so it elaborates as a plain
  // constant function everywhere. The loop stops well short of bit 31 so
  // the shifted constant never turns negative.
  function automatic int clog2_cnt(input int width);
    int result;
    result = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < (width + 1)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sipo_word_deser_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
//
// Serial shift register plus bit counter for the word deserialiser.
// Accepts one bit per clock when d_valid is high, in the bit order selected
// by MSB_FIRST, and flags the edge on which a word completes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   d          in   serial data bit
//   d_valid    in   d is accepted only when high
//   q          out  live shift-register contents
//   bit_count  out  bits accepted into the current word, 0..WIDTH-1
//   word_done  out  combinational strobe: the coming edge completes a word
//   word_next  out  value q takes on the coming edge when d_valid is high
//                   (this is the completed word when word_done is high)
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = MSB_FIRST_ORDER,
  parameter int CNT_W     = clog2_cnt(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_done,
  output logic [WIDTH-1:0] word_next
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic last_bit;

  // Shift direction is fixed at elaboration: MSB-first pushes new bits in at
  // the bottom so the first bit ends up in the MSB; LSB-first pushes them in
  // at the top so the first bit ends up in the LSB.
  generate
    if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb_first
      assign word_next = {q[WIDTH-2:0], d};
    end else begin : g_lsb_first
      assign word_next = {d, q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit  = (bit_count == LAST_BIT);
  assign word_done = d_valid && last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      bit_count <= '0;
    end else if (d_valid) begin
      q <= word_next;
      // The counter wraps on the completing edge so bit 0 of the next word
      // can follow with no bubble.
      if (last_bit) begin
        bit_count <= '0;
      end else begin
        bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_word_deser.sv
// ---------------------------------------------------------------------------
// sipo_word_deser
//
// Parametrised serial-in/parallel-out deserialiser. Serial bits are
// assembled into WIDTH-bit words by sipo_shift_core; each completed word is
// captured in a holding register and offered to the consumer with a
// valid/ready handshake. A word that completes while the holding register
// is still full and not being consumed is dropped and raises a sticky
// overrun flag.
//
// Parameters:
//   WIDTH      word size in bits, 2..32
//   MSB_FIRST  1 = first received bit lands in the MSB, 0 = in the LSB
//   CNT_W      width of bit_count (derived)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   d           in   serial data bit
//   d_valid     in   d is sampled only when high
//   word_ready  in   consumer accepts word_out this cycle
//   clr_ovr     in   clears the sticky overrun flag
//   word_out    out  last completed word (holding register)
//   word_valid  out  word_out holds an unconsumed word
//   overrun     out  sticky: a completed word was dropped
//   q           out  live shift-register contents
//   bit_count   out  bits accepted into the current word, 0..WIDTH-1
// ---------------------------------------------------------------------------
module sipo_word_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = MSB_FIRST_ORDER,
  parameter int CNT_W     = clog2_cnt(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             word_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overrun,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] bit_count
);

  logic             word_done;
  logic [WIDTH-1:0] word_next;
  logic             consume;
  logic             load_word;
  logic             drop_word;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_shift_core (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q),
    .bit_count (bit_count),
    .word_done (word_done),
    .word_next (word_next)
  );

  // The holding register is free for a new word either when it is empty or
  // when its current word is being consumed on this very edge; otherwise a
  // completing word has nowhere to go and is dropped.
  assign consume   = word_valid && word_ready;
  assign load_word = word_done && (!word_valid || word_ready);
  assign drop_word = word_done && word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_word) begin
      word_out   <= word_next;
      word_valid <= 1'b1;
    end else if (consume) begin
      word_valid <= 1'b0;
    end
  end

  // Setting takes priority over clearing so an overrun that coincides with
  // clr_ovr is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop_word) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_word_deser.sv
// ---------------------------------------------------------------------------
// tb_sipo_word_deser
//
// Self-checking bench for sipo_word_deser. Three instances share one set of
// inputs: WIDTH=4 MSB-first, WIDTH=4 LSB-first and WIDTH=8 MSB-first. A
// vector table drives the WIDTH=4 pair through ordered assembly, gapped
// input, overrun and its clear, same-edge complete/consume, back-to-back
// words and set-beats-clear on overrun. A hand-written sequence then covers
// the WIDTH=8 mid-word reset and a fresh 8'hA5 word.
// ---------------------------------------------------------------------------
module tb_sipo_word_deser;

  logic clk = 1'b0;
  logic rst, d, d_valid, word_ready, clr_ovr;

  logic [3:0] m4_word, m4_q, l4_word, l4_q;
  logic       m4_valid, m4_ovr, l4_valid, l4_ovr;
  logic [2:0] m4_cnt, l4_cnt;

  logic [7:0] m8_word, m8_q;
  logic       m8_valid, m8_ovr;
  logic [3:0] m8_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sipo_word_deser #(.WIDTH(4), .MSB_FIRST(1)) u_m4 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .word_ready(word_ready),
    .clr_ovr(clr_ovr), .word_out(m4_word), .word_valid(m4_valid),
    .overrun(m4_ovr), .q(m4_q), .bit_count(m4_cnt)
  );

  sipo_word_deser #(.WIDTH(4), .MSB_FIRST(0)) u_l4 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .word_ready(word_ready),
    .clr_ovr(clr_ovr), .word_out(l4_word), .word_valid(l4_valid),
    .overrun(l4_ovr), .q(l4_q), .bit_count(l4_cnt)
  );

  sipo_word_deser #(.WIDTH(8), .MSB_FIRST(1)) u_m8 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .word_ready(word_ready),
    .clr_ovr(clr_ovr), .word_out(m8_word), .word_valid(m8_valid),
    .overrun(m8_ovr), .q(m8_q), .bit_count(m8_cnt)
  );

  typedef struct {
    logic       rst;
    logic       d;
    logic       dv;
    logic       rdy;
    logic       clr;
    logic [3:0] m_word;
    logic [3:0] l_word;
    logic [3:0] m_q;
    logic [3:0] l_q;
    logic       valid;
    logic       ovr;
    logic [2:0] cnt;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  // Drive one cycle of inputs, let the edge happen, then settle before
  // anything is sampled.
  task automatic applyStimulus(input logic r, input logic dd, input logic dv,
                               input logic rdy, input logic clr);
    rst        = r;
    d          = dd;
    d_valid    = dv;
    word_ready = rdy;
    clr_ovr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s step %0d: got 'h%0h, expected 'h%0h",
               name, step, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; d_valid = 1'b0; word_ready = 1'b0; clr_ovr = 1'b0;

    //            rst d dv rdy clr  m_word   l_word   m_q      l_q      v  o  cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 3'd0};
    vecs[1]  = '{0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 0, 0, 3'd1};
    vecs[2]  = '{0, 0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 0, 0, 3'd2};
    vecs[3]  = '{0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 0, 0, 3'd3};
    vecs[4]  = '{0, 1, 1, 0, 0, 4'b1011, 4'b1101, 4'b1011, 4'b1101, 1, 0, 3'd0};
    vecs[5]  = '{0, 0, 1, 0, 0, 4'b1011, 4'b1101, 4'b0110, 4'b0110, 1, 0, 3'd1};
    vecs[6]  = '{0, 1, 1, 0, 0, 4'b1011, 4'b1101, 4'b1101, 4'b1011, 1, 0, 3'd2};
    vecs[7]  = '{0, 1, 1, 0, 0, 4'b1011, 4'b1101, 4'b1011, 4'b1101, 1, 0, 3'd3};
    vecs[8]  = '{0, 0, 1, 0, 0, 4'b1011, 4'b1101, 4'b0110, 4'b0110, 1, 1, 3'd0};
    vecs[9]  = '{0, 0, 0, 0, 1, 4'b1011, 4'b1101, 4'b0110, 4'b0110, 1, 0, 3'd0};
    vecs[10] = '{0, 0, 1, 0, 0, 4'b1011, 4'b1101, 4'b1100, 4'b0011, 1, 0, 3'd1};
    vecs[11] = '{0, 0, 1, 0, 0, 4'b1011, 4'b1101, 4'b1000, 4'b0001, 1, 0, 3'd2};
    vecs[12] = '{0, 1, 1, 0, 0, 4'b1011, 4'b1101, 4'b0001, 4'b1000, 1, 0, 3'd3};
    vecs[13] = '{0, 1, 1, 1, 0, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 1, 0, 3'd0};
    vecs[14] = '{0, 0, 0, 1, 0, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 0, 0, 3'd0};
    vecs[15] = '{0, 1, 1, 0, 0, 4'b0011, 4'b1100, 4'b0111, 4'b1110, 0, 0, 3'd1};
    vecs[16] = '{0, 1, 0, 0, 0, 4'b0011, 4'b1100, 4'b0111, 4'b1110, 0, 0, 3'd1};
    vecs[17] = '{0, 0, 1, 0, 0, 4'b0011, 4'b1100, 4'b1110, 4'b0111, 0, 0, 3'd2};
    vecs[18] = '{0, 1, 0, 0, 0, 4'b0011, 4'b1100, 4'b1110, 4'b0111, 0, 0, 3'd2};
    vecs[19] = '{0, 0, 1, 0, 0, 4'b0011, 4'b1100, 4'b1100, 4'b0011, 0, 0, 3'd3};
    vecs[20] = '{0, 1, 0, 0, 0, 4'b0011, 4'b1100, 4'b1100, 4'b0011, 0, 0, 3'd3};
    vecs[21] = '{0, 1, 1, 0, 0, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 1, 0, 3'd0};
    vecs[22] = '{0, 0, 1, 1, 0, 4'b1001, 4'b1001, 4'b0010, 4'b0100, 0, 0, 3'd1};
    vecs[23] = '{0, 1, 1, 1, 0, 4'b1001, 4'b1001, 4'b0101, 4'b1010, 0, 0, 3'd2};
    vecs[24] = '{0, 0, 1, 1, 0, 4'b1001, 4'b1001, 4'b1010, 4'b0101, 0, 0, 3'd3};
    vecs[25] = '{0, 0, 1, 0, 0, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 1, 0, 3'd0};
    vecs[26] = '{0, 1, 1, 0, 0, 4'b0100, 4'b0010, 4'b1001, 4'b1001, 1, 0, 3'd1};
    vecs[27] = '{0, 1, 1, 0, 0, 4'b0100, 4'b0010, 4'b0011, 4'b1100, 1, 0, 3'd2};
    vecs[28] = '{0, 1, 1, 0, 0, 4'b0100, 4'b0010, 4'b0111, 4'b1110, 1, 0, 3'd3};
    vecs[29] = '{0, 1, 1, 0, 1, 4'b0100, 4'b0010, 4'b1111, 4'b1111, 1, 1, 3'd0};
    vecs[30] = '{0, 0, 0, 0, 0, 4'b0100, 4'b0010, 4'b1111, 4'b1111, 1, 1, 3'd0};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].d, vecs[i].dv, vecs[i].rdy, vecs[i].clr);
      checkOutput("m4_word_out",   i, 32'(m4_word),  32'(vecs[i].m_word));
      checkOutput("m4_q",          i, 32'(m4_q),     32'(vecs[i].m_q));
      checkOutput("m4_word_valid", i, 32'(m4_valid), 32'(vecs[i].valid));
      checkOutput("m4_overrun",    i, 32'(m4_ovr),   32'(vecs[i].ovr));
      checkOutput("m4_bit_count",  i, 32'(m4_cnt),   32'(vecs[i].cnt));
      checkOutput("l4_word_out",   i, 32'(l4_word),  32'(vecs[i].l_word));
      checkOutput("l4_q",          i, 32'(l4_q),     32'(vecs[i].l_q));
      checkOutput("l4_word_valid", i, 32'(l4_valid), 32'(vecs[i].valid));
      checkOutput("l4_overrun",    i, 32'(l4_ovr),   32'(vecs[i].ovr));
      checkOutput("l4_bit_count",  i, 32'(l4_cnt),   32'(vecs[i].cnt));
    end

    // WIDTH=8: five bits 1,1,0,1,0 then a reset that must win over a valid bit.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("m8_reset_q", 100, 32'(m8_q), 32'h0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("m8_partial_q",   101, 32'(m8_q),   32'h1A);
    checkOutput("m8_partial_cnt", 101, 32'(m8_cnt), 32'd5);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("m8_midreset_q",     102, 32'(m8_q),     32'h0);
    checkOutput("m8_midreset_cnt",   102, 32'(m8_cnt),   32'd0);
    checkOutput("m8_midreset_valid", 102, 32'(m8_valid), 32'd0);
    checkOutput("m8_midreset_word",  102, 32'(m8_word),  32'h0);

    // Fresh 8'hA5 stream, MSB first.
    begin
      logic [7:0] pattern;
      pattern = 8'hA5;
      for (int b = 7; b >= 1; b--) begin
        applyStimulus(0, pattern[b], 1, 0, 0);
      end
      checkOutput("m8_pre_cnt",   103, 32'(m8_cnt),   32'd7);
      checkOutput("m8_pre_valid", 103, 32'(m8_valid), 32'd0);
      applyStimulus(0, pattern[0], 1, 0, 0);
    end
    checkOutput("m8_word_out", 104, 32'(m8_word),  32'hA5);
    checkOutput("m8_valid",    104, 32'(m8_valid), 32'd1);
    checkOutput("m8_q",        104, 32'(m8_q),     32'hA5);
    checkOutput("m8_cnt",      104, 32'(m8_cnt),   32'd0);
    checkOutput("m8_overrun",  104, 32'(m8_ovr),   32'd0);

    // Consume it; the holding register must empty but keep its contents.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("m8_consumed_valid", 105, 32'(m8_valid), 32'd0);
    checkOutput("m8_consumed_word",  105, 32'(m8_word),  32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sipo_word_deser.md
Name: sipo_word_deser

Overview:
Parametrised serial-in/parallel-out deserialiser, the successor of the fixed 4-bit SIPO.
- Accepts one qualified serial bit per clock and assembles WIDTH-bit words in either bit order.
- Presents each completed word in a holding register with a valid/ready handshake.
- Flags overruns and exposes the live shift contents and bit count for debug.

Parameters:
WIDTH, 8, word size in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in word MSB; 0 = first bit lands in LSB.
CNT_W, $clog2(WIDTH+1), width of bit_count; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
d  input  1  serial data bit
d_valid  input  1  d is sampled only when high
word_ready  input  1  consumer accepts word_out this cycle
clr_ovr  input  1  clears the sticky overrun flag
word_out  output  WIDTH  last completed word (holding register)
word_valid  output  1  word_out holds an unconsumed word
overrun  output  1  sticky; a completed word was dropped
q  output  WIDTH  live shift-register contents
bit_count  output  CNT_W  bits accepted into the current word, 0..WIDTH-1

Behaviour:
- All state updates on the rising clk edge. No combinational path from inputs to outputs.
- Reset: with rst=1 at an edge, clear q, word_out, word_valid, overrun and bit_count to 0. Reset overrides every other input. A partial word in progress is discarded.
- Shift, when d_valid=1:
  - MSB_FIRST=1: q <= {q[WIDTH-2:0], d}.
  - MSB_FIRST=0: q <= {d, q[WIDTH-1:1]}.
  - When d_valid=0, q and bit_count hold.
- Count: bit_count increments on each accepted bit. It wraps to 0 on the accepting edge when bit_count == WIDTH-1.
- Completion event: d_valid=1 and bit_count == WIDTH-1.
  - The assembled word is the next value of q (including the current d).
  - It is written to word_out on the same edge, so word_valid is seen 1 cycle after the last bit is sampled.
- Handshake:
  - A word is consumed on an edge where word_valid=1 and word_ready=1.
  - word_valid stays high and word_out stays stable until consumed.
  - word_ready while word_valid=0 is ignored.
- Boundary: completion and consume on the same edge. The new word loads and word_valid stays 1. No overrun.
- Boundary: completion while word_valid=1 and word_ready=0.
  - The new word is dropped and word_out keeps the old word.
  - overrun <= 1.
  - q and bit_count still shift and wrap normally.
- overrun is sticky until an edge with clr_ovr=1. If clr_ovr and a new overrun occur on the same edge, the set wins.
- Back-to-back words: bit 0 of the next word may be accepted on the same edge as the completion. No bubble is needed.
- Throughput: 1 bit/cycle sustained. A consumer that asserts word_ready within WIDTH-1 cycles of word_valid never overruns.

Decomposition:
- Package sipo_pkg holds:
  - the function clog2_cnt(WIDTH) giving CNT_W;
  - localparams for bit-order encodings MSB_FIRST_ORDER=1 and LSB_FIRST_ORDER=0.
- One natural sub-module, sipo_shift_core. It contains the shift register plus bit counter and emits q, bit_count and a word_done strobe.
- The top level contains the holding register, handshake and overrun logic.

Test Plan:
1. WIDTH=4, MSB_FIRST=1. Reset, then d_valid=1 with d=1,0,1,1 on consecutive cycles and word_ready=0. Required: word_out=4'b1011 and word_valid=1 one cycle after the 4th bit; bit_count sequence 1,2,3,0.
2. Same bits with MSB_FIRST=0. Required: word_out=4'b1101.
3. WIDTH=4. d_valid toggled 1,0,1,0,... with d=1,0,0,1 on the valid cycles. Required: q and bit_count hold on invalid cycles; word_out=4'b1001.
4. WIDTH=4, word_ready=0. Stream 8 bits 1,0,1,1 then 0,1,1,0. Required: word_out stays 4'b1011 and overrun=1. Then clr_ovr=1 for one cycle: overrun=0.
5. WIDTH=4. word_ready=1 pulsed on the edge the second word completes. Required: word_out updates to the second word, word_valid stays 1, overrun stays 0.
6. WIDTH=8. Assert rst after 5 accepted bits. Required: the next edge gives q=0, bit_count=0, word_valid=0. A fresh 8-bit stream 8'hA5 then yields word_out=8'hA5.
